// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register and write-back formatter.
// Captures the MEM-stage result, extracts and extends load data from the raw
// data-memory word, and drives the register-file write port. Emits a retire
// pulse per instruction entering WB.
// Optional feature: define WB_INSTRET_CNT_EN to build the 64-bit
// retired-instruction counter; otherwise instret_o is tied to zero.
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              mem_valid_i,
  input  logic              mem_rd_we_i,
  input  logic [ADDR_W-1:0] mem_rd_addr_i,
  input  logic [DATA_W-1:0] mem_result_i,
  input  logic              mem_load_i,
  input  logic [2:0]        mem_funct3_i,
  input  logic [1:0]        mem_addr_lo_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              rd_we_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [DATA_W-1:0] rd_wdata_o,
  output logic              wb_valid_o,
  output logic              retire_o,
  output logic [63:0]       instret_o
);

  logic              valid_q,  valid_d;
  logic              we_q,     we_d;
  logic [ADDR_W-1:0] addr_q,   addr_d;
  logic [DATA_W-1:0] wdata_q,  wdata_d;
  logic              retire_q, retire_d;

  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [DATA_W-1:0] fmt_data;

  // Pick the addressed byte/halfword and extend it; halfword offset bit 0 is
  // ignored since misaligned accesses never reach this stage.
  always_comb begin
    byte_sel = mem_rdata_i[{mem_addr_lo_i, 3'b000} +: 8];
    half_sel = mem_rdata_i[{mem_addr_lo_i[1], 4'b0000} +: 16];
    fmt_data = mem_result_i;
    if (mem_load_i) begin
      case (mem_funct3_i)
        3'b000:  fmt_data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
        3'b001:  fmt_data = {{(DATA_W-16){half_sel[15]}}, half_sel};
        3'b100:  fmt_data = {{(DATA_W-8){1'b0}}, byte_sel};
        3'b101:  fmt_data = {{(DATA_W-16){1'b0}}, half_sel};
        default: fmt_data = mem_rdata_i;  // LW and undefined encodings
      endcase
    end
  end

  // Next WB contents: flush beats stall beats capture. A stall holds the
  // entry but drops the retire pulse so it is never repeated.
  always_comb begin
    valid_d  = valid_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    retire_d = 1'b0;
    if (flush_i) begin
      valid_d = 1'b0;
      we_d    = 1'b0;
      addr_d  = '0;
      wdata_d = '0;
    end else if (!stall_i) begin
      valid_d  = mem_valid_i;
      we_d     = mem_valid_i & mem_rd_we_i & (mem_rd_addr_i != '0);
      addr_d   = mem_rd_addr_i;
      wdata_d  = fmt_data;
      retire_d = mem_valid_i;
    end
  end

  // WB pipeline register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      retire_q <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      retire_q <= retire_d;
    end
  end

  assign rd_we_o    = we_q;
  assign rd_addr_o  = addr_q;
  assign rd_wdata_o = wdata_q;
  assign wb_valid_o = valid_q;
  assign retire_o   = retire_q;

`ifdef WB_INSTRET_CNT_EN
  logic [63:0] instret_q, instret_d;

  // Count at the edge closing each retire cycle; wraps naturally at 2^64.
  always_comb instret_d = instret_q + {63'd0, retire_q};

  // Retired-instruction counter register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) instret_q <= 64'h0;
    else       instret_q <= instret_d;
  end

  assign instret_o = instret_q;
`else
  assign instret_o = 64'h0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed, table-driven bench for mem_wb_stage with hand-computed results.
module tb_mem_wb_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        stall_i, flush_i;
  logic        mem_valid_i, mem_rd_we_i, mem_load_i;
  logic [4:0]  mem_rd_addr_i;
  logic [31:0] mem_result_i, mem_rdata_i;
  logic [2:0]  mem_funct3_i;
  logic [1:0]  mem_addr_lo_i;
  logic        rd_we_o, wb_valid_o, retire_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_wdata_o;
  logic [63:0] instret_o;

  mem_wb_stage #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .mem_valid_i(mem_valid_i), .mem_rd_we_i(mem_rd_we_i),
    .mem_rd_addr_i(mem_rd_addr_i), .mem_result_i(mem_result_i),
    .mem_load_i(mem_load_i), .mem_funct3_i(mem_funct3_i),
    .mem_addr_lo_i(mem_addr_lo_i), .mem_rdata_i(mem_rdata_i),
    .rd_we_o(rd_we_o), .rd_addr_o(rd_addr_o), .rd_wdata_o(rd_wdata_o),
    .wb_valid_o(wb_valid_o), .retire_o(retire_o), .instret_o(instret_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    logic        flush, stall, valid, we, load;
    logic [4:0]  addr;
    logic [31:0] result, rdata;
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic        e_we, e_valid, e_retire;
    logic [4:0]  e_addr;
    logic [31:0] e_wdata;
  } vec_t;

  vec_t        vecs[$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] ecnt   = 64'd0;  // modelled instret
  logic        prev_r = 1'b0;   // modelled retire before the current edge
`ifdef WB_INSTRET_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  task automatic cmp(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // One check per clock edge; advances the instret model.
  task automatic chk(string nm, logic we, logic [4:0] a, logic [31:0] d,
                     logic v, logic r);
    ecnt   = ecnt + {63'd0, prev_r};
    prev_r = r;
    cmp({nm, ".rd_we"},    {63'd0, rd_we_o},    {63'd0, we});
    cmp({nm, ".rd_addr"},  {59'd0, rd_addr_o},  {59'd0, a});
    cmp({nm, ".rd_wdata"}, {32'd0, rd_wdata_o}, {32'd0, d});
    cmp({nm, ".wb_valid"}, {63'd0, wb_valid_o}, {63'd0, v});
    cmp({nm, ".retire"},   {63'd0, retire_o},   {63'd0, r});
    cmp({nm, ".instret"},  instret_o, CNT_EN ? ecnt : 64'd0);
  endtask

  task automatic drive(logic fl, logic st, logic v, logic we, logic [4:0] a,
                       logic [31:0] res, logic ld, logic [2:0] f3,
                       logic [1:0] lo, logic [31:0] rdat);
    flush_i = fl; stall_i = st; mem_valid_i = v; mem_rd_we_i = we;
    mem_rd_addr_i = a; mem_result_i = res; mem_load_i = ld;
    mem_funct3_i = f3; mem_addr_lo_i = lo; mem_rdata_i = rdat;
  endtask

  task automatic tick;
    @(posedge clk_i); #1;
  endtask

  task automatic add(string n, logic fl, logic st, logic v, logic we,
                     logic [4:0] a, logic [31:0] res, logic ld, logic [2:0] f3,
                     logic [1:0] lo, logic [31:0] rdat, logic ewe,
                     logic [4:0] ea, logic [31:0] ed, logic ev, logic er);
    vec_t t;
    t.name = n; t.flush = fl; t.stall = st; t.valid = v; t.we = we;
    t.addr = a; t.result = res; t.load = ld; t.f3 = f3; t.lo = lo;
    t.rdata = rdat; t.e_we = ewe; t.e_addr = ea; t.e_wdata = ed;
    t.e_valid = ev; t.e_retire = er;
    vecs.push_back(t);
  endtask

  localparam logic [31:0] RD = 32'h80FF7F01;

  initial begin
    // name     fl st v we addr res  ld f3 lo rdata | we addr wdata valid ret
    add("lb3",   0,0,1,1, 5'd6, 32'h0, 1,3'b000,2'd3,RD, 1,5'd6, 32'hFFFFFF80,1,1);
    add("lbu1",  0,0,1,1, 5'd7, 32'h0, 1,3'b100,2'd1,RD, 1,5'd7, 32'h0000007F,1,1);
    add("lh2",   0,0,1,1, 5'd8, 32'h0, 1,3'b001,2'd2,RD, 1,5'd8, 32'hFFFF80FF,1,1);
    add("lhu0",  0,0,1,1, 5'd9, 32'h0, 1,3'b101,2'd0,RD, 1,5'd9, 32'h00007F01,1,1);
    add("lw",    0,0,1,1, 5'd10,32'h0, 1,3'b010,2'd2,RD, 1,5'd10,32'h80FF7F01,1,1);
    add("f3_011",0,0,1,1, 5'd11,32'h0, 1,3'b011,2'd1,RD, 1,5'd11,32'h80FF7F01,1,1);
    add("f3_111",0,0,1,1, 5'd11,32'h0, 1,3'b111,2'd3,RD, 1,5'd11,32'h80FF7F01,1,1);
    add("lb0",   0,0,1,1, 5'd12,32'h0, 1,3'b000,2'd0,RD, 1,5'd12,32'h00000001,1,1);
    add("lbu2",  0,0,1,1, 5'd13,32'h0, 1,3'b100,2'd2,RD, 1,5'd13,32'h000000FF,1,1);
    add("lh0",   0,0,1,1, 5'd14,32'h0, 1,3'b001,2'd0,RD, 1,5'd14,32'h00007F01,1,1);
    add("lh3",   0,0,1,1, 5'd15,32'h0, 1,3'b001,2'd3,RD, 1,5'd15,32'hFFFF80FF,1,1);
    add("lhu2",  0,0,1,1, 5'd16,32'h0, 1,3'b101,2'd2,RD, 1,5'd16,32'h000080FF,1,1);
    add("x0",    0,0,1,1, 5'd0, 32'hDEAD,0,3'b000,2'd0,RD, 0,5'd0, 32'h0000DEAD,1,1);
    add("inval", 0,0,0,1, 5'd7, 32'h55,0,3'b000,2'd0,RD, 0,5'd7, 32'h00000055,0,0);
    add("nowe",  0,0,1,0, 5'd9, 32'h11,0,3'b000,2'd0,RD, 0,5'd9, 32'h00000011,1,1);
    add("flush", 1,0,1,1, 5'd9, 32'h22,0,3'b000,2'd0,RD, 0,5'd0, 32'h00000000,0,0);

    // Reset held with MEM active: everything stays zero.
    rst_i = 1'b1;
    drive(0,0,1,1,5'd5,32'h1234,0,3'b000,2'd0,32'h0);
    #2;
    repeat (2) begin
      tick;
      chk("reset", 0, 5'd0, 32'h0, 0, 0);
    end
    rst_i = 1'b0;
    tick;
    chk("addi_x5", 1, 5'd5, 32'h00001234, 1, 1);

    foreach (vecs[i]) begin
      drive(vecs[i].flush, vecs[i].stall, vecs[i].valid, vecs[i].we,
            vecs[i].addr, vecs[i].result, vecs[i].load, vecs[i].f3,
            vecs[i].lo, vecs[i].rdata);
      tick;
      chk(vecs[i].name, vecs[i].e_we, vecs[i].e_addr, vecs[i].e_wdata,
          vecs[i].e_valid, vecs[i].e_retire);
    end

    // Capture then stall three cycles while MEM inputs wander.
    drive(0,0,1,1,5'd20,32'hAAAA,0,3'b000,2'd0,RD);
    tick;
    chk("stall_cap", 1, 5'd20, 32'h0000AAAA, 1, 1);
    for (int k = 0; k < 3; k++) begin
      drive(0,1,1,1,5'(21+k),32'(32'h1000+k),1,3'b000,2'(k),RD);
      tick;
      chk("stall_hold", 1, 5'd20, 32'h0000AAAA, 1, 0);
    end

    // Flush and stall together: the flush wins.
    drive(1,1,1,1,5'd22,32'h77,0,3'b000,2'd0,RD);
    tick;
    chk("flush_stall", 0, 5'd0, 32'h0, 0, 0);

    // Asynchronous reset during a stall clears without a clock edge.
    drive(0,0,1,1,5'd3,32'h3333,0,3'b000,2'd0,RD);
    tick;
    chk("pre_rst_cap", 1, 5'd3, 32'h00003333, 1, 1);
    drive(0,1,1,1,5'd4,32'h4444,0,3'b000,2'd0,RD);
    tick;
    chk("pre_rst_stall", 1, 5'd3, 32'h00003333, 1, 0);
    #2 rst_i = 1'b1;
    #1;
    ecnt = 64'd0; prev_r = 1'b0;
    cmp("async_rst.rd_we",    {63'd0, rd_we_o},    64'd0);
    cmp("async_rst.wb_valid", {63'd0, wb_valid_o}, 64'd0);
    cmp("async_rst.rd_wdata", {32'd0, rd_wdata_o}, 64'd0);
    cmp("async_rst.instret",  instret_o,           64'd0);
    tick;
    rst_i = 1'b0;

    // Ten back-to-back valid instructions, then one idle cycle.
    for (int k = 0; k < 10; k++) begin
      drive(0,0,1,1,5'(k+1),32'(k*3),0,3'b000,2'd0,RD);
      tick;
      chk("b2b", 1, 5'(k+1), 32'(k*3), 1, 1);
    end
    drive(0,0,0,0,5'd0,32'h0,0,3'b000,2'd0,RD);
    tick;
    chk("b2b_idle", 0, 5'd0, 32'h0, 0, 0);
    cmp("instret_10", instret_o, CNT_EN ? 64'd10 : 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
